// File: rtl/sat_counter_pht.sv
// Pattern-history table of 2**IDX_W saturating counters, CNT_W bits each.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   PredReq      prediction request this cycle
//   PredIndex    entry to predict from
//   PredValid    registered: PredReq delayed one cycle
//   PredTaken    registered: MSB of the selected counter
//   PredCount    registered: full value of the selected counter
//   UpdValid     resolved-branch update this cycle
//   UpdIndex     entry to train
//   BranchTaken  resolved outcome (ignored when UpdValid=0)
//   Flush        synchronous: return every counter to INIT
//
// A prediction reports the value the counter holds after this edge. A same-cycle
// update to the same entry is therefore visible (bypass), and a same-cycle flush
// makes the prediction return INIT. A flush also discards any same-cycle update.
module sat_counter_pht #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned INIT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PredReq,
  input  logic [IDX_W-1:0] PredIndex,
  output logic             PredValid,
  output logic             PredTaken,
  output logic [CNT_W-1:0] PredCount,
  input  logic             UpdValid,
  input  logic [IDX_W-1:0] UpdIndex,
  input  logic             BranchTaken,
  input  logic             Flush
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned CMax  = (2 ** CNT_W) - 1;

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CMax);
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(INIT);

  // Reject an INIT that does not fit in the counter.
  if (INIT > CMax) begin : g_init_check
    $error("sat_counter_pht: INIT exceeds 2**CNT_W-1");
  end

  logic [CNT_W-1:0] cnt_q [Depth];
  logic [CNT_W-1:0] cnt_d [Depth];

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0] pred_count_q, pred_count_d;

  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_next;
  logic [CNT_W-1:0] pred_next;

  // Saturating step: never wraps in either direction.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic             taken);
    logic [CNT_W-1:0] r;
    r = c;
    if (taken) begin
      if (c != CntMax) r = c + CNT_W'(1);
    end else begin
      if (c != '0) r = c - CNT_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    upd_cur  = cnt_q[UpdIndex];
    upd_next = upd_cur;
    // BranchTaken is only looked at under UpdValid so an X there cannot leak.
    if (UpdValid) begin
      upd_next = sat_step(upd_cur, BranchTaken);
    end
  end

  // Counter array next state: flush beats update.
  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (Flush) begin
      for (int i = 0; i < int'(Depth); i++) begin
        cnt_d[i] = CntInit;
      end
    end else if (UpdValid) begin
      cnt_d[UpdIndex] = upd_next;
    end
  end

  // Prediction sees the post-edge value of the addressed counter.
  always_comb begin
    pred_next = cnt_q[PredIndex];
    if (Flush) begin
      pred_next = CntInit;
    end else if (UpdValid && (PredIndex == UpdIndex)) begin
      pred_next = upd_next;
    end
  end

  always_comb begin
    pred_valid_d = PredReq;
    pred_taken_d = pred_taken_q;
    pred_count_d = pred_count_q;
    if (PredReq) begin
      pred_count_d = pred_next;
      pred_taken_d = pred_next[CNT_W-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        cnt_q[i] <= CntInit;
      end
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_count_q <= pred_count_d;
    end
  end

  assign PredValid = pred_valid_q;
  assign PredTaken = pred_taken_q;
  assign PredCount = pred_count_q;

endmodule
